// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - state encoding shared by the sequential divider family
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift partial remainder, trial subtract
module div_step
    import divider_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW:0]   r,
    input  logic [DW-1:0] d,
    output logic [DW:0]   r_next,
    output logic          q_bit
);

    logic [DW:0] s;

    // r < d always holds, so the shift cannot lose a set bit
    always_comb begin
        s      = r << 1;
        q_bit  = (s >= {1'b0, d});
        r_next = q_bit ? (s - {1'b0, d}) : s;
    end

endmodule

// File: rtl/param_seq_divider.sv
// rtl/param_seq_divider.sv - radix-2 sequential fractional divider, QW quotient bits per request
// Optional remainder output: PARAM_SEQ_DIVIDER_REMAINDER_EN
module param_seq_divider
    import divider_pkg::*;
#(
    parameter int DW = 16,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          clr,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          ready,
    output logic          valid,
    output logic [QW-1:0] quotient,
    output logic          dbz,
    output logic          ovf
`ifdef PARAM_SEQ_DIVIDER_REMAINDER_EN
    ,
    output logic [DW-1:0] remainder
`endif
);

    localparam int            CW   = $clog2(QW) + 1;
    localparam logic [CW-1:0] LAST = CW'(QW - 1);

    div_state_t    state;
    div_state_t    state_next;
    logic [DW:0]   r_reg;
    logic [DW:0]   r_step;
    logic [DW-1:0] d_reg;
    logic [QW-1:0] q_reg;
    logic [QW-1:0] q_step;
    logic [CW-1:0] count;
    logic          q_bit;
    logic          div_zero;
    logic          too_big;
    logic          last_step;

    div_step #(
        .DW(DW)
    ) u_step (
        .r      (r_step_in()),
        .d      (d_reg),
        .r_next (r_step),
        .q_bit  (q_bit)
    );

    function automatic logic [DW:0] r_step_in();
        return r_reg;
    endfunction

    always_comb begin
        div_zero   = (divisor == '0);
        too_big    = (dividend >= divisor);
        last_step  = (count == LAST);
        q_step     = (q_reg << 1) | QW'(q_bit);
        ready      = (state == IDLE);
        valid      = (state == DONE);
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = (div_zero || too_big) ? DONE : CALC;
                CALC:    if (last_step) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result registers only change on a completed request; an abort leaves them untouched
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_reg     <= '0;
            d_reg     <= '0;
            q_reg     <= '0;
            count     <= '0;
            quotient  <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
`ifdef PARAM_SEQ_DIVIDER_REMAINDER_EN
            remainder <= '0;
`endif
        end else if (clr) begin
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (div_zero) begin
                            quotient  <= '1;
                            dbz       <= 1'b1;
                            ovf       <= 1'b0;
`ifdef PARAM_SEQ_DIVIDER_REMAINDER_EN
                            remainder <= '0;
`endif
                        end else if (too_big) begin
                            quotient  <= '1;
                            dbz       <= 1'b0;
                            ovf       <= 1'b1;
`ifdef PARAM_SEQ_DIVIDER_REMAINDER_EN
                            remainder <= dividend;
`endif
                        end else begin
                            r_reg <= {1'b0, dividend};
                            d_reg <= divisor;
                            q_reg <= '0;
                            count <= '0;
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_step;
                    q_reg <= q_step;
                    count <= count + CW'(1);
                    if (last_step) begin
                        quotient  <= q_step;
                        dbz       <= 1'b0;
                        ovf       <= 1'b0;
`ifdef PARAM_SEQ_DIVIDER_REMAINDER_EN
                        remainder <= r_step[DW-1:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
